cond_logic: RTL

- Consumer end of the ALU flag interface.
- Holds the architectural NZCV flag register, written from the ALU `flags` bus {N,Z,C,V}.
- Evaluates the 4-bit instruction condition field against the stored flags.
- Gates the decoder's PC, register and memory write enables. Sits between the main decoder/ALU and the datapath write ports.

---
 rtl/cond_pkg.sv | 41 ++++
 rtl/cond_check.sv | 48 ++++
 rtl/cond_logic.sv | 88 ++++++++
 3 files changed

// File: rtl/cond_pkg.sv
// Shared types and field indices for the condition-code / NZCV flag logic.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cond_pkg;

    // Instruction condition field encodings
    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    // Bit positions inside the {N,Z,C,V} flag word
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Bit positions inside the flag_w write-enable pair
    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;

    // Signed greater-or-equal holds when the sign matches the overflow
    function automatic logic signed_ge(input logic [3:0] flags);
        return flags[FLAG_N] == flags[FLAG_V];
    endfunction

endpackage

// File: rtl/cond_check.sv
// Evaluates a 4-bit condition field against an {N,Z,C,V} flag word.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n_f;
    logic z_f;
    logic c_f;
    logic v_f;
    logic ge_f;

    assign n_f  = flags[FLAG_N];
    assign z_f  = flags[FLAG_Z];
    assign c_f  = flags[FLAG_C];
    assign v_f  = flags[FLAG_V];
    assign ge_f = signed_ge(flags);

    // Condition table; the reserved NV code never passes
    always_comb begin
        cond_ex = 1'b0;
        case (cond_e'(cond))
            EQ:      cond_ex = z_f;
            NE:      cond_ex = ~z_f;
            CS:      cond_ex = c_f;
            CC:      cond_ex = ~c_f;
            MI:      cond_ex = n_f;
            PL:      cond_ex = ~n_f;
            VS:      cond_ex = v_f;
            VC:      cond_ex = ~v_f;
            HI:      cond_ex = c_f & ~z_f;
            LS:      cond_ex = ~c_f | z_f;
            GE:      cond_ex = ge_f;
            LT:      cond_ex = ~ge_f;
            GT:      cond_ex = ~z_f & ge_f;
            LE:      cond_ex = z_f | ~ge_f;
            AL:      cond_ex = 1'b1;
            NV:      cond_ex = 1'b0;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Architectural NZCV register plus condition gating of PC/register/memory writes.
// Latency: gated writes and cond_ex are combinational; flags_q/cond_ex_q update one edge later.
// Backpressure: en=0 stalls all state; gated outputs still track inputs.
module cond_logic
    import cond_pkg::*;
#(
    parameter bit         CONDEX_REG  = 1'b0,
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       pcs,
    input  logic       reg_w,
    input  logic       mem_w,
    input  logic       no_write,
    output logic       pc_src,
    output logic       reg_write,
    output logic       mem_write,
    output logic       cond_ex,
    output logic       cond_ex_q,
    output logic [3:0] flags_q
);

    logic [3:0] flags_r;
    logic       pass;
    logic       wr_nz;
    logic       wr_cv;

    // Condition always sees the stored flags, so an instruction observes
    // only results of earlier instructions (no ALU bypass).
    cond_check u_cond_check (
        .cond    (cond),
        .flags   (flags_r),
        .cond_ex (pass)
    );

    // A failed condition also suppresses the instruction's own flag update
    assign wr_nz = en & pass & flag_w[FW_NZ];
    assign wr_cv = en & pass & flag_w[FW_CV];

    // NZ and CV halves are written independently
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_r <= FLAGS_RESET;
        end else begin
            if (wr_nz) begin
                flags_r[FLAG_N:FLAG_Z] <= alu_flags[FLAG_N:FLAG_Z];
            end
            if (wr_cv) begin
                flags_r[FLAG_C:FLAG_V] <= alu_flags[FLAG_C:FLAG_V];
            end
        end
    end

    generate
        if (CONDEX_REG) begin : g_condex_reg
            logic cond_ex_r;

            // Multicycle cores consume the condition result one enabled edge later
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cond_ex_r <= 1'b0;
                end else if (en) begin
                    cond_ex_r <= pass;
                end
            end

            assign cond_ex_q = cond_ex_r;
        end else begin : g_condex_comb
            assign cond_ex_q = 1'b0;
        end
    endgenerate

    // Decoder write requests pass only when the condition holds
    always_comb begin
        pc_src    = pcs & pass;
        reg_write = reg_w & pass & ~no_write;
        mem_write = mem_w & pass;
    end

    assign cond_ex = pass;
    assign flags_q = flags_r;

endmodule
